qs_arb: RTL and testbench
=========================

Name: qs_arb

Overview:
- Packet-level round-robin arbiter that shares one qs sorter instance between N requesters.
- Grants one requester per packet (sop..eop) and forwards its beats to the qs input port.
- Records the requester ID of each admitted packet in an in-order tag FIFO.
- Steers each sorted output packet back to its owner with a registered response.
- Sits between the client request ports and the qs datapath.

Parameters:
N, 4, number of requesters (2..8)
W, 32, data width; matches qs OPT_W
TAG_DEPTH, 4, tag FIFO entries (power of two, >=2); maximum packets in flight inside qs

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_vld  in  N  per-requester beat valid
req_sop  in  N  per-requester start of packet
req_eop  in  N  per-requester end of packet
req_dat  in  N*W  per-requester data; requester i occupies bits [i*W +: W]
req_rdy  out  N  per-requester beat accepted
qs_in_vld  out  1  to qs in_vld
qs_in_sop  out  1  to qs in_sop
qs_in_eop  out  1  to qs in_eop
qs_in_dat  out  W  to qs in_dat
qs_in_rdy  in  1  from qs in_rdy
qs_out_vld  in  1  from qs out_vld_r
qs_out_sop  in  1  from qs out_sop_r
qs_out_eop  in  1  from qs out_eop_r
qs_out_err  in  1  from qs out_err_r
qs_out_dat  in  W  from qs out_dat_r
rsp_vld_r  out  N  one-hot response valid to the owning requester
rsp_sop_r  out  1  response sop (shared)
rsp_eop_r  out  1  response eop (shared)
rsp_err_r  out  1  response err: qs err OR orphan beat
rsp_dat_r  out  W  response data (shared)
stray_r  out  1  sticky flag: orphan output beat or dropped non-sop beat seen

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM enters IDLE.
  - Round-robin pointer = 0; tag FIFO empty.
  - All rsp_* outputs = 0; stray_r = 0.
  - Any packet in progress is abandoned. The qs instance is reset by the same signal.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - Candidates are requesters with req_vld & req_sop.
  - If the tag FIFO is not full, select the first candidate at or after the pointer, in modulo-N order.
  - Register the winner as g, push g into the tag FIFO, go to BUSY.
  - No beat is accepted in the grant cycle.
  - If the tag FIFO is full, no grant is issued.
  - A requester with req_vld & !req_sop in IDLE gets req_rdy=1. Its beat is discarded and stray_r is set.
- BUSY:
  - qs_in_vld/sop/eop/dat = req_*[g] (combinational).
  - req_rdy[g] = qs_in_rdy; req_rdy = 0 for all other requesters.
  - A beat is accepted when qs_in_vld & qs_in_rdy.
  - An accepted beat with eop: go to IDLE; pointer = (g+1) mod N.
  - A req_sop[g] asserted mid-packet is forwarded unchanged; qs flags it through out_err.
- Minimum input cost per packet: 1 grant cycle + L beats. Back-to-back packets have a one-cycle bubble.
- Output side (registered, 1-cycle latency):
  - On qs_out_vld with the tag FIFO non-empty, the next cycle shows:
    - rsp_vld_r = onehot(head tag);
    - rsp_sop_r/eop_r/dat_r copied from qs;
    - rsp_err_r = qs_out_err.
  - Pop the tag FIFO on qs_out_vld & qs_out_eop.
  - On qs_out_vld with the tag FIFO empty (orphan beat):
    - rsp_vld_r = 0, rsp_err_r = 1, rsp_sop_r/eop_r/dat_r still copied from qs;
    - stray_r set.
  - Otherwise rsp_vld_r = 0 and the remaining rsp fields hold their previous values.
- Tag FIFO:
  - A push (IDLE grant) and a pop (output eop) in the same cycle are both honoured; occupancy is unchanged.
  - Full/empty use pointers one bit wider than log2(TAG_DEPTH) and wrap modulo 2*TAG_DEPTH.
  - "Full" is evaluated before the same-cycle pop, so a pop never enables a grant in the same cycle.
- Responses carry no backpressure; requesters must always accept.

Test Plan:
- Single packet from requester 2, beats 5,1,3 (sop on 5, eop on 3), N=4:
  - Grant one cycle after sop; qs_in sees 5,1,3.
  - Response 1,3,5 appears on rsp_vld_r=4'b0100 one cycle after each qs beat; FIFO ends empty.
- All 4 requesters present sop-valid packets continuously from reset:
  - Grant order is 0,1,2,3,0.
  - Each response packet arrives only on the matching rsp_vld_r bit, in admission order.
- TAG_DEPTH=2 with output delayed by qs:
  - Third grant is withheld until the first output eop pops the FIFO.
  - Grant occurs the cycle after the pop, never the same cycle.
- Requester 1 drives vld without sop while IDLE:
  - req_rdy[1]=1 for that beat, nothing reaches qs, stray_r=1 and remains 1.
- Force qs_out_vld with the tag FIFO empty:
  - Next cycle rsp_err_r=1, rsp_vld_r=0, stray_r=1.
- Assert rst=0 mid-packet from requester 3:
  - Outputs go to 0 immediately (asynchronously).
  - After release, a new packet from requester 0 is granted first (pointer reset to 0).

Source files
------------

// File: rtl/qs_arb.sv
// qs_arb -- packet-level round-robin arbiter in front of a shared qs sorter.
//
// Grants one requester per packet (sop..eop), forwards its beats to the qs
// input port, remembers the owner of every admitted packet in an in-order
// tag FIFO and steers each sorted output packet back to that owner through
// a registered response port.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   req_vld/sop/eop   per-requester beat valid / start / end of packet (N)
//   req_dat           per-requester data, requester i at [i*W +: W]
//   req_rdy           per-requester beat accepted (N)
//   qs_in_*           beat stream towards qs (vld/sop/eop/dat, rdy back)
//   qs_out_*          sorted stream from qs (vld/sop/eop/err/dat)
//   rsp_vld_r         one-hot response valid to the owning requester (N)
//   rsp_sop/eop/err/dat_r  shared registered response fields
//   stray_r           sticky: orphan output beat or dropped non-sop beat seen
module qs_arb #(
    parameter int N         = 4,
    parameter int W         = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_vld,
    input  logic [N-1:0]   req_sop,
    input  logic [N-1:0]   req_eop,
    input  logic [N*W-1:0] req_dat,
    output logic [N-1:0]   req_rdy,
    output logic           qs_in_vld,
    output logic           qs_in_sop,
    output logic           qs_in_eop,
    output logic [W-1:0]   qs_in_dat,
    input  logic           qs_in_rdy,
    input  logic           qs_out_vld,
    input  logic           qs_out_sop,
    input  logic           qs_out_eop,
    input  logic           qs_out_err,
    input  logic [W-1:0]   qs_out_dat,
    output logic [N-1:0]   rsp_vld_r,
    output logic           rsp_sop_r,
    output logic           rsp_eop_r,
    output logic           rsp_err_r,
    output logic [W-1:0]   rsp_dat_r,
    output logic           stray_r
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = $clog2(TAG_DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [GW-1:0]   tag_mem_q [TAG_DEPTH];
    logic [N-1:0]    rsp_vld_q, rsp_vld_d;
    logic            rsp_sop_q, rsp_sop_d;
    logic            rsp_eop_q, rsp_eop_d;
    logic            rsp_err_q, rsp_err_d;
    logic [W-1:0]    rsp_dat_q, rsp_dat_d;
    logic            stray_q, stray_d;

    logic [N-1:0]    cand;
    logic            found;
    logic [GW-1:0]   pick;
    int              idx;
    logic            fifo_full, fifo_empty, push, pop;
    logic [GW-1:0]   head_tag;
    logic [N-1:0]    rdy_c;
    logic [N-1:0]    drop_c;

    // Occupancy pointers are one bit wider than the address so that
    // full and empty are distinguishable when the addresses match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_tag   = tag_mem_q[rd_ptr_q[AW-1:0]];
    assign pop        = qs_out_vld & qs_out_eop & ~fifo_empty;

    // Non-sop beats offered while no packet is granted are swallowed.
    assign drop_c     = (state_q == IDLE) ? (req_vld & ~req_sop) : '0;

    // First sop-valid requester at or after the pointer, modulo N.
    always_comb begin
        cand  = req_vld & req_sop;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        ptr_d     = ptr_q;
        push      = 1'b0;
        rdy_c     = '0;
        qs_in_vld = 1'b0;
        qs_in_sop = 1'b0;
        qs_in_eop = 1'b0;
        qs_in_dat = '0;
        case (state_q)
            IDLE: begin
                rdy_c = drop_c;
                // Full is taken before any same-cycle pop on purpose.
                if (found && !fifo_full) begin
                    g_d     = pick;
                    push    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                qs_in_vld    = req_vld[g_q];
                qs_in_sop    = req_sop[g_q];
                qs_in_eop    = req_eop[g_q];
                qs_in_dat    = req_dat[int'(g_q)*W +: W];
                rdy_c[g_q]   = qs_in_rdy;
                if (qs_in_vld && qs_in_rdy && qs_in_eop) begin
                    state_d = IDLE;
                    ptr_d   = (g_q == GW'(N-1)) ? '0 : g_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Nothing is acknowledged while reset is held.
    assign req_rdy = rdy_c & {N{rst}};

    always_comb begin
        wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
        rsp_vld_d = '0;
        rsp_sop_d = rsp_sop_q;
        rsp_eop_d = rsp_eop_q;
        rsp_err_d = rsp_err_q;
        rsp_dat_d = rsp_dat_q;
        stray_d   = stray_q | (|drop_c);
        if (qs_out_vld) begin
            rsp_sop_d = qs_out_sop;
            rsp_eop_d = qs_out_eop;
            rsp_dat_d = qs_out_dat;
            if (!fifo_empty) begin
                rsp_vld_d = N'(1) << head_tag;
                rsp_err_d = qs_out_err;
            end else begin
                // Output beat with no owner on record.
                rsp_err_d = 1'b1;
                stray_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            g_q       <= '0;
            ptr_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rsp_vld_q <= '0;
            rsp_sop_q <= 1'b0;
            rsp_eop_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_dat_q <= '0;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            ptr_q     <= ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_sop_q <= rsp_sop_d;
            rsp_eop_q <= rsp_eop_d;
            rsp_err_q <= rsp_err_d;
            rsp_dat_q <= rsp_dat_d;
            stray_q   <= stray_d;
        end
    end

    // Tag storage needs no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q[AW-1:0]] <= pick;
    end

    assign rsp_vld_r = rsp_vld_q;
    assign rsp_sop_r = rsp_sop_q;
    assign rsp_eop_r = rsp_eop_q;
    assign rsp_err_r = rsp_err_q;
    assign rsp_dat_r = rsp_dat_q;
    assign stray_r   = stray_q;

endmodule

// File: tb/tb_qs_arb.sv
// Self-checking bench for qs_arb (N=4, W=32, TAG_DEPTH=2). The bench plays
// the role of the qs sorter by driving the qs_out_* port directly.
module tb_qs_arb;

    logic         clk;
    logic         rst;
    logic [3:0]   req_vld, req_sop, req_eop, req_rdy;
    logic [127:0] req_dat;
    logic         qs_in_vld, qs_in_sop, qs_in_eop, qs_in_rdy;
    logic [31:0]  qs_in_dat;
    logic         qs_out_vld, qs_out_sop, qs_out_eop, qs_out_err;
    logic [31:0]  qs_out_dat;
    logic [3:0]   rsp_vld_r;
    logic         rsp_sop_r, rsp_eop_r, rsp_err_r, stray_r;
    logic [31:0]  rsp_dat_r;

    int n_cmp = 0;
    int n_bad = 0;

    qs_arb #(.N(4), .W(32), .TAG_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_sop(req_sop), .req_eop(req_eop),
        .req_dat(req_dat), .req_rdy(req_rdy),
        .qs_in_vld(qs_in_vld), .qs_in_sop(qs_in_sop), .qs_in_eop(qs_in_eop),
        .qs_in_dat(qs_in_dat), .qs_in_rdy(qs_in_rdy),
        .qs_out_vld(qs_out_vld), .qs_out_sop(qs_out_sop),
        .qs_out_eop(qs_out_eop), .qs_out_err(qs_out_err),
        .qs_out_dat(qs_out_dat),
        .rsp_vld_r(rsp_vld_r), .rsp_sop_r(rsp_sop_r), .rsp_eop_r(rsp_eop_r),
        .rsp_err_r(rsp_err_r), .rsp_dat_r(rsp_dat_r), .stray_r(stray_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld, sop, eop;
        logic [31:0] d2;
        logic        qv, qs, qe, qerr;
        logic [31:0] qd;
        logic [3:0]  e_rdy;
        logic        e_iv, e_is, e_ie;
        logic [31:0] e_id;
        logic [3:0]  e_rv;
        logic        e_rs, e_re, e_rerr;
        logic [31:0] e_rd;
        logic        e_stray;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_vld    = '0;
        req_sop    = '0;
        req_eop    = '0;
        req_dat    = '0;
        qs_in_rdy  = 1'b1;
        qs_out_vld = 1'b0;
        qs_out_sop = 1'b0;
        qs_out_eop = 1'b0;
        qs_out_err = 1'b0;
        qs_out_dat = '0;
    endtask

    task automatic set_dat(input int i, input logic [31:0] d);
        req_dat[i*32 +: 32] = d;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    logic [31:0] pend [$];
    int          gorder [$];
    logic [7:0]  seq [4];
    int          exp_ids [6];
    int          ridx;
    logic        prev_v;
    logic [31:0] prev_d;
    logic [31:0] d;

    initial begin
        // Single packet from requester 2; bench-qs returns 1,3,5 (err on 3).
        tbl[0] = '{4'h4,4'h4,4'h0,32'd5, 1'b0,1'b0,1'b0,1'b0,32'd0, 4'h0,1'b0,1'b0,1'b0,32'd0, 4'h0,1'b0,1'b0,1'b0,32'd0,1'b0};
        tbl[1] = '{4'h4,4'h4,4'h0,32'd5, 1'b0,1'b0,1'b0,1'b0,32'd0, 4'h4,1'b1,1'b1,1'b0,32'd5, 4'h0,1'b0,1'b0,1'b0,32'd0,1'b0};
        tbl[2] = '{4'h4,4'h0,4'h0,32'd1, 1'b0,1'b0,1'b0,1'b0,32'd0, 4'h4,1'b1,1'b0,1'b0,32'd1, 4'h0,1'b0,1'b0,1'b0,32'd0,1'b0};
        tbl[3] = '{4'h4,4'h0,4'h4,32'd3, 1'b0,1'b0,1'b0,1'b0,32'd0, 4'h4,1'b1,1'b0,1'b1,32'd3, 4'h0,1'b0,1'b0,1'b0,32'd0,1'b0};
        tbl[4] = '{4'h0,4'h0,4'h0,32'd0, 1'b1,1'b1,1'b0,1'b0,32'd1, 4'h0,1'b0,1'b0,1'b0,32'd0, 4'h0,1'b0,1'b0,1'b0,32'd0,1'b0};
        tbl[5] = '{4'h0,4'h0,4'h0,32'd0, 1'b1,1'b0,1'b0,1'b1,32'd3, 4'h0,1'b0,1'b0,1'b0,32'd0, 4'h4,1'b1,1'b0,1'b0,32'd1,1'b0};
        tbl[6] = '{4'h0,4'h0,4'h0,32'd0, 1'b1,1'b0,1'b1,1'b0,32'd5, 4'h0,1'b0,1'b0,1'b0,32'd0, 4'h4,1'b0,1'b0,1'b1,32'd3,1'b0};
        tbl[7] = '{4'h0,4'h0,4'h0,32'd0, 1'b0,1'b0,1'b0,1'b0,32'd0, 4'h0,1'b0,1'b0,1'b0,32'd0, 4'h4,1'b0,1'b1,1'b0,32'd5,1'b0};
        tbl[8] = '{4'h0,4'h0,4'h0,32'd0, 1'b0,1'b0,1'b0,1'b0,32'd0, 4'h0,1'b0,1'b0,1'b0,32'd0, 4'h0,1'b0,1'b1,1'b0,32'd5,1'b0};

        idle_inputs();
        rst = 1'b0;
        #12;
        chk("reset_rsp_vld", 32'(rsp_vld_r), 32'h0);
        chk("reset_rsp_dat", rsp_dat_r, 32'h0);
        chk("reset_stray", 32'(stray_r), 32'h0);
        chk("reset_qs_in_vld", 32'(qs_in_vld), 32'h0);
        next_cyc();
        rst = 1'b1;

        // ---- single packet, table driven ----
        for (int r = 0; r < 9; r++) begin
            idle_inputs();
            req_vld    = tbl[r].vld;
            req_sop    = tbl[r].sop;
            req_eop    = tbl[r].eop;
            set_dat(2, tbl[r].d2);
            qs_out_vld = tbl[r].qv;
            qs_out_sop = tbl[r].qs;
            qs_out_eop = tbl[r].qe;
            qs_out_err = tbl[r].qerr;
            qs_out_dat = tbl[r].qd;
            @(negedge clk);
            chk($sformatf("pkt%0d_req_rdy", r), 32'(req_rdy), 32'(tbl[r].e_rdy));
            chk($sformatf("pkt%0d_in_vld", r), 32'(qs_in_vld), 32'(tbl[r].e_iv));
            chk($sformatf("pkt%0d_in_sop", r), 32'(qs_in_sop), 32'(tbl[r].e_is));
            chk($sformatf("pkt%0d_in_eop", r), 32'(qs_in_eop), 32'(tbl[r].e_ie));
            chk($sformatf("pkt%0d_in_dat", r), qs_in_dat, tbl[r].e_id);
            chk($sformatf("pkt%0d_rsp_vld", r), 32'(rsp_vld_r), 32'(tbl[r].e_rv));
            chk($sformatf("pkt%0d_rsp_sop", r), 32'(rsp_sop_r), 32'(tbl[r].e_rs));
            chk($sformatf("pkt%0d_rsp_eop", r), 32'(rsp_eop_r), 32'(tbl[r].e_re));
            chk($sformatf("pkt%0d_rsp_err", r), 32'(rsp_err_r), 32'(tbl[r].e_rerr));
            chk($sformatf("pkt%0d_rsp_dat", r), rsp_dat_r, tbl[r].e_rd);
            chk($sformatf("pkt%0d_stray", r), 32'(stray_r), 32'(tbl[r].e_stray));
            next_cyc();
        end

        // ---- non-sop beat from requester 1 while idle ----
        idle_inputs();
        req_vld[1] = 1'b1;
        set_dat(1, 32'h77);
        @(negedge clk);
        chk("drop_req_rdy", 32'(req_rdy), 32'h2);
        chk("drop_in_vld", 32'(qs_in_vld), 32'h0);
        chk("drop_stray_before", 32'(stray_r), 32'h0);
        next_cyc();
        idle_inputs();
        @(negedge clk);
        chk("drop_stray_set", 32'(stray_r), 32'h1);
        chk("drop_in_vld_after", 32'(qs_in_vld), 32'h0);
        repeat (3) next_cyc();
        @(negedge clk);
        chk("drop_stray_sticky", 32'(stray_r), 32'h1);

        // ---- orphan output beat ----
        do_reset();
        qs_out_vld = 1'b1;
        qs_out_sop = 1'b1;
        qs_out_eop = 1'b1;
        qs_out_dat = 32'hAA;
        @(negedge clk);
        chk("orphan_stray_before", 32'(stray_r), 32'h0);
        next_cyc();
        idle_inputs();
        @(negedge clk);
        chk("orphan_rsp_err", 32'(rsp_err_r), 32'h1);
        chk("orphan_rsp_vld", 32'(rsp_vld_r), 32'h0);
        chk("orphan_stray", 32'(stray_r), 32'h1);
        chk("orphan_rsp_dat", rsp_dat_r, 32'hAA);
        chk("orphan_rsp_sop", 32'(rsp_sop_r), 32'h1);

        // ---- all requesters continuously, single-beat packets ----
        do_reset();
        exp_ids = '{0, 1, 2, 3, 0, 1};
        ridx    = 0;
        prev_v  = 1'b0;
        prev_d  = '0;
        for (int i = 0; i < 4; i++) seq[i] = 8'h0;
        for (int c = 0; c < 12; c++) begin
            idle_inputs();
            req_vld = 4'hF;
            req_sop = 4'hF;
            req_eop = 4'hF;
            for (int i = 0; i < 4; i++) set_dat(i, {16'h0, 8'(i), seq[i]});
            if (pend.size() > 0) begin
                d          = pend.pop_front();
                qs_out_vld = 1'b1;
                qs_out_sop = 1'b1;
                qs_out_eop = 1'b1;
                qs_out_dat = d;
            end
            @(negedge clk);
            if (prev_v) begin
                chk($sformatf("rr_rsp%0d_vld", ridx), 32'(rsp_vld_r), 32'(4'b0001 << exp_ids[ridx]));
                chk($sformatf("rr_rsp%0d_dat", ridx), rsp_dat_r, prev_d);
                ridx++;
            end else begin
                chk($sformatf("rr_c%0d_rsp_idle", c), 32'(rsp_vld_r), 32'h0);
            end
            prev_v = qs_out_vld;
            prev_d = qs_out_dat;
            if (qs_in_vld && qs_in_rdy) begin
                gorder.push_back(int'(qs_in_dat[15:8]));
                pend.push_back(qs_in_dat);
                seq[int'(qs_in_dat[9:8])] = seq[int'(qs_in_dat[9:8])] + 8'h1;
            end
            next_cyc();
        end
        chk("rr_grant_count", 32'(gorder.size() >= 5), 32'h1);
        for (int k = 0; k < 5; k++) begin
            if (k < gorder.size()) chk($sformatf("rr_grant%0d", k), 32'(gorder[k]), 32'(exp_ids[k]));
        end

        // ---- tag FIFO full (depth 2) ----
        do_reset();
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            req_vld = (c < 2) ? 4'b0111 : (c < 4) ? 4'b0110 : 4'b0100;
            req_sop = req_vld;
            req_eop = req_vld;
            for (int i = 0; i < 3; i++) set_dat(i, 32'hD0 + 32'(i));
            if (c == 6) begin
                qs_out_vld = 1'b1;
                qs_out_sop = 1'b1;
                qs_out_eop = 1'b1;
                qs_out_dat = 32'hE0;
            end
            @(negedge clk);
            case (c)
                1: begin
                    chk("full_c1_in_dat", qs_in_dat, 32'hD0);
                    chk("full_c1_req_rdy", 32'(req_rdy), 32'h1);
                end
                3: begin
                    chk("full_c3_in_dat", qs_in_dat, 32'hD1);
                    chk("full_c3_req_rdy", 32'(req_rdy), 32'h2);
                end
                7: begin
                    chk("full_c7_in_vld", 32'(qs_in_vld), 32'h0);
                    chk("full_c7_req_rdy", 32'(req_rdy), 32'h0);
                    chk("full_c7_rsp_vld", 32'(rsp_vld_r), 32'h1);
                end
                8: begin
                    chk("full_c8_in_vld", 32'(qs_in_vld), 32'h1);
                    chk("full_c8_req_rdy", 32'(req_rdy), 32'h4);
                    chk("full_c8_in_dat", qs_in_dat, 32'hD2);
                end
                default: chk($sformatf("full_c%0d_in_vld", c), 32'(qs_in_vld), 32'h0);
            endcase
            next_cyc();
        end

        // ---- asynchronous reset mid-packet ----
        do_reset();
        req_vld = 4'b0010; req_sop = 4'b0010; req_eop = 4'b0010;
        set_dat(1, 32'h11);
        next_cyc();                     // grant 1
        next_cyc();                     // beat accepted, pointer -> 2
        idle_inputs();
        req_vld = 4'b1000; req_sop = 4'b1000;
        set_dat(3, 32'h31);
        next_cyc();                     // grant 3
        qs_out_vld = 1'b1;
        qs_out_sop = 1'b1;
        qs_out_dat = 32'h55;
        @(negedge clk);
        chk("arst_busy_in_vld", 32'(qs_in_vld), 32'h1);
        chk("arst_busy_req_rdy", 32'(req_rdy), 32'h8);
        next_cyc();
        idle_inputs();
        req_vld = 4'b1000;
        set_dat(3, 32'h32);
        @(negedge clk);
        chk("arst_pre_rsp_vld", 32'(rsp_vld_r), 32'h2);
        chk("arst_pre_rsp_dat", rsp_dat_r, 32'h55);
        #1 rst = 1'b0;
        #1;
        chk("arst_rsp_vld", 32'(rsp_vld_r), 32'h0);
        chk("arst_rsp_dat", rsp_dat_r, 32'h0);
        chk("arst_rsp_sop", 32'(rsp_sop_r), 32'h0);
        chk("arst_in_vld", 32'(qs_in_vld), 32'h0);
        chk("arst_req_rdy", 32'(req_rdy), 32'h0);
        next_cyc();
        rst = 1'b1;
        idle_inputs();
        req_vld = 4'b1001; req_sop = 4'b1001; req_eop = 4'b1001;
        set_dat(0, 32'h01);
        set_dat(3, 32'h33);
        next_cyc();                     // grant cycle
        @(negedge clk);
        chk("arst_regrant_req_rdy", 32'(req_rdy), 32'h1);
        chk("arst_regrant_in_dat", qs_in_dat, 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
